// File: rtl/s3ga_wb_cfg_loader_if.sv
// Wishbone slave port bundle for the S3GA configuration loader.
// Signal names follow the Caravel user-project Wishbone port.
interface s3ga_wb_cfg_loader_if #(
    parameter int DATA_W = 32
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [DATA_W/8-1:0]   wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [DATA_W-1:0]     wbs_dat_i;
    logic                  wbs_ack_o;
    logic [DATA_W-1:0]     wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/s3ga_wb_cfg_loader.sv
// Wishbone-fed, count-driven loader that streams bitstream words into N_CHAINS parallel S3GA config chains.
// Optional CRC-16/CCITT over loaded words is enabled by defining S3GA_CFG_CRC_EN.
module s3ga_wb_cfg_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DATA_W     = 32,
    parameter int          N_CHAINS   = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    s3ga_wb_cfg_loader_if.slave     wb,
    output logic [N_CHAINS-1:0]     cfg_d_o,
    output logic                    cfg_we_o,
    output logic                    cfg_done_o,
    output logic                    irq_o
);

    localparam int BEATS  = DATA_W / N_CHAINS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {REG_CTRL, REG_COUNT, REG_DATA, REG_CRC} reg_t;

    state_t              state;
    reg_t                reg_sel;
    logic                ack_q;
    logic [DATA_W-1:0]   dat_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    remaining;
    logic                ovf_q;
    logic                done_q;
    logic [DATA_W-1:0]   shreg;
    logic [BEAT_W-1:0]   beat;
    logic [15:0]         crc_val;
    logic [DATA_W-1:0]   rd_data;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [DATA_W-1:0]   head;

    logic hit, req, wr_req, ctrl_wr, data_req, count_wr;
    logic start, abort, done_clr;
    logic busy, fifo_full, fifo_empty;
    logic pop, push, drop, stall, accept;
    logic unused_adr;

    // Each chain takes the lowest bit of its DATA_W/N_CHAINS slice of the word.
    function automatic logic [N_CHAINS-1:0] column(input logic [DATA_W-1:0] w);
        logic [N_CHAINS-1:0] c;
        // NOTE: blocking assignments belong in functions and always_comb; registered state uses <= only.
        c = '0;
        for (int i = 0; i < N_CHAINS; i++) begin
            c[i] = w[i*BEATS];
        end
        return c;
    endfunction

    assign busy       = (state != ST_IDLE);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign head       = mem[rd_ptr];

    assign hit      = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req      = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
    assign reg_sel  = reg_t'(wb.wbs_adr_i[3:2]);
    assign wr_req   = req & wb.wbs_we_i & (&wb.wbs_sel_i);
    assign ctrl_wr  = wr_req & (reg_sel == REG_CTRL);
    assign data_req = wr_req & (reg_sel == REG_DATA);
    assign count_wr = wr_req & (reg_sel == REG_COUNT) & ~busy;

    assign abort    = ctrl_wr & wb.wbs_dat_i[1];
    assign start    = ctrl_wr & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[1] & ~busy;
    assign done_clr = ctrl_wr & wb.wbs_dat_i[2];

    // A full-FIFO DATA write waits while loading, but is accepted in the cycle the FSM frees a slot.
    assign pop    = (state == ST_FETCH) & ~fifo_empty & ~abort;
    assign stall  = data_req & fifo_full & busy & ~pop;
    assign accept = req & ~stall;
    assign push   = data_req & accept & (~fifo_full | pop);
    assign drop   = data_req & accept & fifo_full & ~pop;

    assign unused_adr = ^wb.wbs_adr_i[1:0];

    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred.
        rd_data = '0;
        unique case (reg_sel)
            REG_CTRL: begin
                rd_data[0]          = busy;
                rd_data[1]          = done_q;
                rd_data[2]          = ovf_q;
                rd_data[8 +: LVL_W] = level;
            end
            REG_COUNT: rd_data[CNT_W-1:0] = count_q;
            REG_DATA:  rd_data[CNT_W-1:0] = remaining;
            REG_CRC:   rd_data[15:0]      = crc_val;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept & ~wb.wbs_we_i) ? rd_data : '0;
            if (count_wr) begin
                count_q <= wb.wbs_dat_i[CNT_W-1:0];
            end
            if (abort) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // NOTE: FIFO storage carries no reset; the pointers and level alone define its contents.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wb.wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // The shift register moves right each beat, so chain i always reads bit i*BEATS.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            shreg      <= '0;
            beat       <= '0;
            cfg_we_o   <= 1'b0;
            cfg_d_o    <= '0;
            cfg_done_o <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cfg_done_o <= 1'b0;
            if (done_clr) begin
                done_q <= 1'b0;
            end
            if (abort) begin
                state     <= ST_IDLE;
                remaining <= '0;
                cfg_we_o  <= 1'b0;
                cfg_d_o   <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (count_q != '0) begin
                                state     <= ST_FETCH;
                                remaining <= count_q;
                            end else begin
                                state      <= ST_DONE;
                                cfg_done_o <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (pop) begin
                            shreg    <= head >> 1;
                            beat     <= '0;
                            cfg_we_o <= 1'b1;
                            cfg_d_o  <= column(head);
                            state    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (beat == LAST_BEAT) begin
                            cfg_we_o  <= 1'b0;
                            cfg_d_o   <= '0;
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                state      <= ST_DONE;
                                cfg_done_o <= 1'b1;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end else begin
                            beat    <= beat + BEAT_W'(1);
                            cfg_d_o <= column(shreg);
                            shreg   <= shreg >> 1;
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign irq_o = done_q;

`ifdef S3GA_CFG_CRC_EN
    localparam logic [15:0] CRC_SEED = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    logic [15:0] crc_q;

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [DATA_W-1:0] w);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[15] ^ w[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ CRC_POLY;
            end
        end
        return r;
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || start || abort) begin
            crc_q <= CRC_SEED;
        end else if (pop) begin
            crc_q <= crc_word(crc_q, head);
        end
    end

    assign crc_val = crc_q;
`else
    assign crc_val = '0;
`endif

endmodule

// File: tb/tb_s3ga_wb_cfg_loader.sv
// Directed bench for s3ga_wb_cfg_loader: register map, chain bit order, FIFO stall/overflow, abort, reset.
module tb_s3ga_wb_cfg_loader;

    localparam logic [31:0] A_CTRL  = 32'h3000_0000;
    localparam logic [31:0] A_COUNT = 32'h3000_0004;
    localparam logic [31:0] A_DATA  = 32'h3000_0008;
    localparam logic [31:0] A_CRC   = 32'h3000_000C;
`ifdef S3GA_CFG_CRC_EN
    localparam logic [31:0] CRC_AT_RESET = 32'h0000_FFFF;
    localparam logic [31:0] CRC_ZERO_WORD = 32'h0000_84C0;
`else
    localparam logic [31:0] CRC_AT_RESET = 32'h0;
    localparam logic [31:0] CRC_ZERO_WORD = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_d;
    logic        cfg_we;
    logic        cfg_done;
    logic        irq;

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  beats[$];
    int          done_pulses = 0;
    int          d_idle_bad = 0;
    logic [31:0] words[16];

    s3ga_wb_cfg_loader_if #(.DATA_W(32)) wb ();

    s3ga_wb_cfg_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb         (wb),
        .cfg_d_o    (cfg_d),
        .cfg_we_o   (cfg_we),
        .cfg_done_o (cfg_done),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_we) beats.push_back(cfg_d);
        else if (cfg_d != 4'h0) d_idle_bad++;
        if (cfg_done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdat, output int lat);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = wdat;
        wb.wbs_sel_i = sel;
        lat  = -1;
        rdat = '0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) begin
                lat  = c;
                rdat = wb.wbs_dat_o;
                break;
            end
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat, output int lat);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, adr, wdat, 4'hF, 64, unused_rd, lat);
        if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] rdat);
        int lat;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, 64, rdat, lat);
        if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done_pulses == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (done_pulses == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c;
        c = 0;
        while (beats.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (beats.size() < n) check("beat_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [3:0] exp_beat(input logic [31:0] w, input int b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = w[b + 8*i];
        return r;
    endfunction

    task automatic check_stream(input string tag, input int n);
        int bad;
        bad = 0;
        check({tag, "_len"}, beats.size(), n * 8);
        for (int k = 0; k < n * 8 && k < beats.size(); k++) begin
            if (beats[k] !== exp_beat(words[k / 8], k % 8)) bad++;
        end
        check({tag, "_bits"}, bad, 0);
    endtask

    task automatic clear_mon();
        beats.delete();
        done_pulses = 0;
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        int          max_lat;

        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb.wbs_ack_o, 0);
        check("rst_we", cfg_we, 0);
        check("rst_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;

        rd(A_CTRL, r);  check("rst_ctrl", r, 32'h0);
        rd(A_COUNT, r); check("rst_count", r, 32'h0);
        rd(A_CRC, r);   check("rst_crc", r, CRC_AT_RESET);

        // Two-word load and chain bit mapping
        clear_mon();
        words[0] = 32'h1234_5678;
        words[1] = 32'h9ABC_DEF0;
        wr(A_COUNT, 32'd2, lat);
        wr(A_DATA, words[0], lat);
        wr(A_DATA, words[1], lat);
        wr(A_CTRL, 32'h1, lat);
        wait_done(200);
        check_stream("two_word", 2);
        check("w0_beat3", beats[3], 4'h1);
        check("w0_beat4", beats[4], 4'hF);
        check("w1_beat1", beats[9], 4'hA);
        check("w1_beat7", beats[15], 4'hF);
        rd(A_CTRL, r);  check("done_ctrl", r, 32'h2);
        check("done_pulses", done_pulses, 1);
        check("irq_set", irq, 1);
        rd(A_DATA, r);  check("remaining_0", r, 32'h0);
        wr(A_CTRL, 32'h4, lat);
        check("irq_clear", irq, 0);

        // Idle overflow: ninth word acked at once and dropped
        for (int k = 0; k < 9; k++) wr(A_DATA, 32'h100 + k, lat);
        check("ovf_ack_lat", lat, 1);
        rd(A_CTRL, r);  check("ovf_ctrl", r, 32'h0000_0804);
        wr(A_CTRL, 32'h2, lat);
        rd(A_CTRL, r);  check("abort_clr_ovf", r, 32'h0);

        // Streaming load that outruns the FIFO; pushes must stall, none lost
        clear_mon();
        for (int k = 0; k < 16; k++) words[k] = {8'(k), 8'(8'hA0 + k), 8'(8'h5C ^ k), 8'(k * 7 + 1)};
        wr(A_COUNT, 32'd16, lat);
        wr(A_CTRL, 32'h1, lat);
        max_lat = 0;
        for (int k = 0; k < 16; k++) begin
            wr(A_DATA, words[k], lat);
            if (lat > max_lat) max_lat = lat;
        end
        check("stall_seen", (max_lat > 1), 1);
        wait_done(2000);
        check_stream("stream16", 16);
        check("stream_pulses", done_pulses, 1);
        rd(A_CTRL, r);  check("stream_ctrl", r, 32'h2);
        wr(A_CTRL, 32'h4, lat);

        // Abort during word 3 of 5; COUNT writes ignored while busy
        clear_mon();
        wr(A_COUNT, 32'd5, lat);
        for (int k = 0; k < 5; k++) wr(A_DATA, 32'hF00D_0000 + k, lat);
        wr(A_CTRL, 32'h1, lat);
        rd(A_DATA, r);  check("busy_remaining", r, 32'd5);
        wr(A_COUNT, 32'd7, lat);
        rd(A_COUNT, r); check("count_locked", r, 32'd5);
        wait_beats(19, 300);
        wr(A_CTRL, 32'h3, lat);
        check("abort_we_low", cfg_we, 0);
        check("abort_mid_word", (beats.size() >= 16 && beats.size() < 24), 1);
        rd(A_CTRL, r);  check("abort_ctrl", r, 32'h0);
        rd(A_DATA, r);  check("abort_remaining", r, 32'h0);
        check("abort_no_done", done_pulses, 0);

        clear_mon();
        words[0] = 32'hCAFE_F00D;
        wr(A_COUNT, 32'd1, lat);
        wr(A_DATA, words[0], lat);
        wr(A_CTRL, 32'h1, lat);
        wait_done(200);
        check_stream("after_abort", 1);
        check("after_abort_irq", irq, 1);
        wr(A_CTRL, 32'h4, lat);

        // START with COUNT=0 goes straight to DONE
        clear_mon();
        wr(A_COUNT, 32'd0, lat);
        wr(A_CTRL, 32'h1, lat);
        wait_done(20);
        check("zero_no_beats", beats.size(), 0);
        rd(A_CTRL, r);  check("zero_ctrl", r, 32'h2);
        wr(A_CTRL, 32'h4, lat);

        // CRC of a single zero word
        clear_mon();
        wr(A_COUNT, 32'd1, lat);
        wr(A_DATA, 32'h0, lat);
        wr(A_CTRL, 32'h1, lat);
        wait_done(200);
        rd(A_CRC, r);   check("crc_zero_word", r, CRC_ZERO_WORD);
        wr(A_CTRL, 32'h4, lat);

        // Partial byte-select write is acked but has no effect; address miss is never acked
        wb_xfer(1'b1, A_COUNT, 32'h55, 4'b0111, 8, r, lat);
        check("partial_sel_ack", lat, 1);
        rd(A_COUNT, r); check("partial_sel_ign", r, 32'd1);
        wb_xfer(1'b1, 32'h3000_0010, 32'h1, 4'hF, 4, r, lat);
        check("miss_no_ack", lat, -1);

        // Reset in the middle of a load
        clear_mon();
        wr(A_COUNT, 32'd2, lat);
        wr(A_DATA, 32'hFFFF_FFFF, lat);
        wr(A_DATA, 32'hFFFF_FFFF, lat);
        wr(A_CTRL, 32'h1, lat);
        wait_beats(3, 100);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_we", cfg_we, 0);
        check("mid_rst_d", cfg_d, 0);
        check("mid_rst_done", cfg_done, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_dat", wb.wbs_dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL, r);  check("mid_rst_ctrl", r, 32'h0);
        rd(A_COUNT, r); check("mid_rst_count", r, 32'h0);
        rd(A_CRC, r);   check("mid_rst_crc", r, CRC_AT_RESET);

        check("d_zero_when_idle", d_idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
